// File: rtl/add_sub_arbiter.sv
// Shared FP32 add/subtract unit behind a round-robin arbiter and a two-stage pipeline.
// The combinational add_sub core lives in this file as well, ahead of the arbiter top.

module add_sub (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        op,
  input  logic [2:0]  rm,
  output logic [31:0] z,
  output logic [4:0]  exc  // {invalid, div_by_zero, overflow, underflow, inexact}
);

  localparam logic [2:0] RmRne = 3'd0;
  localparam logic [2:0] RmRtz = 3'd1;
  localparam logic [2:0] RmRdn = 3'd2;
  localparam logic [2:0] RmRup = 3'd3;
  localparam logic [2:0] RmRmm = 3'd4;

  logic        y_s;
  logic        x_nan, y_nan, x_snan, y_snan, x_inf, y_inf;
  logic        swap;
  logic        a_s, b_s;
  logic [7:0]  a_e, b_e;
  logic [22:0] a_f, b_f;
  logic [23:0] a_m, b_m;
  logic [7:0]  a_ee, b_ee, d;
  logic [26:0] a_al, b_al, b_ext, b_shift, lost_mask;
  logic        eff_sub;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic        found;
  logic [7:0]  lim, sh;
  logic [26:0] norm;
  logic [8:0]  e_pre, e_field;
  logic        g, r, s, inexact, inc, res_sign, ovf, ovf_inf;
  logic [30:0] packed_res;

  assign y_s    = y[31] ^ op;
  assign x_nan  = (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
  assign y_nan  = (y[30:23] == 8'hff) && (y[22:0] != 23'd0);
  assign x_snan = x_nan && !x[22];
  assign y_snan = y_nan && !y[22];
  assign x_inf  = (x[30:23] == 8'hff) && (x[22:0] == 23'd0);
  assign y_inf  = (y[30:23] == 8'hff) && (y[22:0] == 23'd0);

  // Operand a is always the larger magnitude so the mantissa difference stays non-negative.
  assign swap = y[30:0] > x[30:0];
  assign a_s  = swap ? y_s : x[31];
  assign b_s  = swap ? x[31] : y_s;
  assign a_e  = swap ? y[30:23] : x[30:23];
  assign b_e  = swap ? x[30:23] : y[30:23];
  assign a_f  = swap ? y[22:0] : x[22:0];
  assign b_f  = swap ? x[22:0] : y[22:0];
  assign a_m  = {a_e != 8'd0, a_f};
  assign b_m  = {b_e != 8'd0, b_f};
  assign a_ee = (a_e == 8'd0) ? 8'd1 : a_e;
  assign b_ee = (b_e == 8'd0) ? 8'd1 : b_e;
  assign d    = a_ee - b_ee;

  assign a_al      = {a_m, 3'b000};
  assign b_ext     = {b_m, 3'b000};
  assign b_shift   = b_ext >> d;
  assign lost_mask = ~(27'h7ffffff << d);

  always_comb begin
    b_al = {26'd0, |b_m};
    if (d < 8'd27) begin
      b_al = {b_shift[26:1], b_shift[0] | (|(b_ext & lost_mask))};
    end
  end

  assign eff_sub = a_s ^ b_s;
  assign sum     = eff_sub ? ({1'b0, a_al} - {1'b0, b_al}) : ({1'b0, a_al} + {1'b0, b_al});

  always_comb begin
    lz    = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end
  end

  // Left shift stops at the minimum exponent; what remains is a subnormal result.
  assign lim = a_ee - 8'd1;
  assign sh  = ({3'd0, lz} > lim) ? lim : {3'd0, lz};

  always_comb begin
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      e_pre = {1'b0, a_ee} + 9'd1;
    end else begin
      norm  = sum[26:0] << sh;
      e_pre = {1'b0, a_ee} - {1'b0, sh};
    end
  end

  assign e_field  = norm[26] ? e_pre : 9'd0;
  assign g        = norm[2];
  assign r        = norm[1];
  assign s        = norm[0];
  assign inexact  = g | r | s;
  assign res_sign = (sum == 28'd0) ? (eff_sub ? (rm == RmRdn) : a_s) : a_s;

  always_comb begin
    case (rm)
      RmRtz:   begin inc = 1'b0;                          ovf_inf = 1'b0;      end
      RmRdn:   begin inc = inexact & res_sign;            ovf_inf = res_sign;  end
      RmRup:   begin inc = inexact & !res_sign;           ovf_inf = !res_sign; end
      RmRmm:   begin inc = g;                             ovf_inf = 1'b1;      end
      default: begin inc = g & (r | s | norm[3]);         ovf_inf = 1'b1;      end
    endcase
  end

  // Mantissa carry ripples into the exponent, covering subnormal->normal and normal->inf.
  assign packed_res = {e_field[7:0], norm[25:3]} + {30'd0, inc};
  assign ovf        = (e_field >= 9'd255) || (packed_res[30:23] == 8'hff);

  always_comb begin
    z   = {res_sign, packed_res};
    exc = {3'b000, inexact && !norm[26], inexact};
    if (x_nan || y_nan) begin
      z   = 32'h7fc00000;
      exc = {x_snan | y_snan, 4'b0000};
    end else if (x_inf && y_inf && (x[31] != y_s)) begin
      z   = 32'h7fc00000;
      exc = 5'b10000;
    end else if (x_inf || y_inf) begin
      z   = {x_inf ? x[31] : y_s, 8'hff, 23'd0};
      exc = 5'b00000;
    end else if (ovf) begin
      z   = ovf_inf ? {res_sign, 8'hff, 23'd0} : {res_sign, 8'hfe, 23'h7fffff};
      exc = 5'b00101;
    end
  end

endmodule

module add_sub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_x,
  input  logic [NUM_REQ*32-1:0] req_y,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [NUM_REQ*3-1:0]  req_rm,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_z,
  output logic [4:0]            rsp_exc,
  output logic [4:0]            exc_sticky,
  input  logic                  exc_clear,
  output logic                  busy
);

  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic            s1_op_q, s1_op_d;
  logic [2:0]      s1_rm_q, s1_rm_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s2_valid_q, s2_valid_d;
  logic [31:0]     s2_z_q, s2_z_d;
  logic [4:0]      s2_exc_q, s2_exc_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [4:0]      sticky_q, sticky_d;

  logic            grant_any;
  logic [ID_W-1:0] grant_idx;
  logic            s2_load, can_accept, accept, rsp_hs;
  logic [31:0]     core_z;
  logic [4:0]      core_exc;

  // First valid requester after the last one served wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!grant_any && req_valid[(int'(last_q) + i) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end

  assign s2_load    = s1_valid_q && (!s2_valid_q || rsp_ready);
  assign can_accept = !s1_valid_q || s2_load;
  assign accept     = rst_n && grant_any && can_accept;
  assign rsp_hs     = s2_valid_q && rsp_ready;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant_idx == ID_W'(i));
    end
  end

  add_sub u_add_sub (
    .x   (s1_x_q),
    .y   (s1_y_q),
    .op  (s1_op_q),
    .rm  (s1_rm_q),
    .z   (core_z),
    .exc (core_exc)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_op_d    = s1_op_q;
    s1_rm_d    = s1_rm_q;
    s1_id_d    = s1_id_q;
    last_d     = last_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_x_d     = req_x[32*grant_idx +: 32];
      s1_y_d     = req_y[32*grant_idx +: 32];
      s1_op_d    = req_op[grant_idx];
      s1_rm_d    = req_rm[3*grant_idx +: 3];
      s1_id_d    = grant_idx;
      last_d     = grant_idx;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_z_d     = s2_z_q;
    s2_exc_d   = s2_exc_q;
    s2_id_d    = s2_id_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_z_d     = core_z;
      s2_exc_d   = core_exc;
      s2_id_d    = s1_id_q;
    end else if (rsp_hs) begin
      s2_valid_d = 1'b0;
    end
  end

  // A clear and a fresh flag in the same cycle keep the fresh flag.
  assign sticky_d = (exc_clear ? 5'd0 : sticky_q) | (rsp_hs ? s2_exc_q : 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_op_q    <= 1'b0;
      s1_rm_q    <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
      s2_exc_q   <= '0;
      s2_id_q    <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
      sticky_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_op_q    <= s1_op_d;
      s1_rm_q    <= s1_rm_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
      s2_exc_q   <= s2_exc_d;
      s2_id_q    <= s2_id_d;
      last_q     <= last_d;
      sticky_q   <= sticky_d;
    end
  end

  assign rsp_valid  = s2_valid_q;
  assign rsp_id     = s2_id_q;
  assign rsp_z      = s2_z_q;
  assign rsp_exc    = s2_exc_q;
  assign exc_sticky = sticky_q;
  assign busy       = s1_valid_q || s2_valid_q;

endmodule
